swervolf_ddr_gate: RTL and testbench
====================================

SWERVOLF_DDR_GATE -- requirements
Module: swervolf_ddr_gate

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: AXI ID width on all channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: AXI data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have port i_clk, input, 1: single clock, the DDR controller user clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_init_done, input, 1: DDR controller calibration complete, synchronous to i_clk.
REQ-006 SHALL have port i_init_error, input, 1: DDR controller calibration failed, synchronous to i_clk.
REQ-007 SHALL have ports i_aw*, input: subordinate AW channel (id ID_WIDTH, addr 32, len 8, size 3, burst 2, valid 1), with o_awready output 1.
REQ-008 SHALL have ports i_ar*, input: subordinate AR channel, same widths as AW, with o_arready output 1.
REQ-009 SHALL have ports i_wdata/i_wstrb/i_wlast/i_wvalid, input, DATA_WIDTH/DATA_WIDTH/8/1/1, with o_wready output 1.
REQ-010 SHALL have ports o_bid/o_bresp/o_bvalid, output, ID_WIDTH/2/1, with i_bready input 1.
REQ-011 SHALL have ports o_rid/o_rdata/o_rresp/o_rlast/o_rvalid, output, ID_WIDTH/DATA_WIDTH/2/1/1, with i_rready input 1.
REQ-012 SHALL have a mirrored manager-side port set (o_m_aw*, o_m_ar*, o_m_w*, i_m_b*, i_m_r*) toward the DDR controller, same widths.
REQ-013 SHALL have ports o_ready and o_error, output, 1 each: gate state PASS and ERROR respectively.

Function
REQ-014 SHALL implement FSM states WAIT_INIT, PASS, ERROR; WAIT_INIT after reset.
REQ-015 WAIT_INIT SHALL drive all subordinate readies/valids and all manager valids/readies to 0.
REQ-016 WAIT_INIT SHALL go to ERROR when i_init_error=1, else to PASS when i_init_done=1; error wins if both are 1 in the same cycle.
REQ-017 PASS and ERROR SHALL be terminal until reset; later changes on i_init_done/i_init_error SHALL be ignored.
REQ-018 PASS SHALL connect subordinate and manager ports combinationally with zero latency, starting the cycle after the transition.
REQ-019 ERROR SHALL drive all manager-side valids and readies to 0 and serve subordinate traffic locally.
REQ-020 ERROR write engine: accept one AW (o_awready=1 only when idle), capture awid, then o_wready=1 until a beat with i_wlast=1 is accepted.
REQ-021 ERROR write engine: after that, o_bvalid=1 with o_bid=captured id and o_bresp=2'b10 (SLVERR), held until i_bready; idle on the following cycle.
REQ-022 ERROR write engine SHALL ignore W beats before AW acceptance (o_wready=0).
REQ-023 ERROR read engine: accept one AR when idle, capture arid and arlen, then return arlen+1 beats with o_rdata=0 and o_rresp=2'b10.
REQ-024 ERROR read engine: o_rid=captured id on every beat; o_rlast=1 only on the last beat; each beat advances only on i_rready.
REQ-025 The 8-bit beat counter SHALL handle arlen=0 (one beat, rlast=1) and arlen=255 (256 beats) without wrap error.
REQ-026 Read and write engines SHALL operate independently and concurrently.
REQ-027 o_ready and o_error SHALL be registered state decodes.

Reset
REQ-028 On i_rst, the FSM SHALL enter WAIT_INIT and the engines SHALL go idle asynchronously.
REQ-029 During reset, all valids/readies, o_ready, o_error, o_bresp and o_rresp SHALL be 0.
REQ-030 Reset mid-burst SHALL discard the captured id/len and any remaining beats with no response.

Structure
REQ-031 Package swervolf_ddr_gate_pkg SHALL hold the FSM state enum and the RESP_SLVERR=2'b10 constant.
REQ-032 The ERROR-mode read/write responders SHALL be one sub-module, swervolf_axi_err_resp; PASS muxing stays in the top.

Verification
REQ-033 Reset, hold i_init_done=0 for 100 cycles with i_awvalid=1 -> o_awready=0 and o_m_awvalid=0 throughout; o_ready=0.
REQ-034 Pulse i_init_done=1 -> o_ready=1 next cycle; AR id=3 len=3 passes to manager; 4 manager R beats return with rid=3 and rlast on beat 4.
REQ-035 Assert i_init_done and i_init_error in the same cycle -> o_error=1, o_ready=0; AR id=5 len=0 -> one R beat, rresp=2, rlast=1, rid=5.
REQ-036 ERROR, AR len=255 with i_rready toggling -> exactly 256 beats, rlast only on beat 256, rdata=0.
REQ-037 ERROR, W beats sent before AW id=7 len=1 -> o_wready=0 until AW accepted; after 2 beats, bvalid with bid=7 and bresp=2 held until i_bready.
REQ-038 ERROR, assert i_rst at beat 2 of a 4-beat read -> all outputs 0 immediately; after release, state WAIT_INIT and no stale beats.

Source files
------------

// File: rtl/swervolf_ddr_gate_pkg.sv
// Shared types and constants for the DDR init gate and its error responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package swervolf_ddr_gate_pkg;

  // Gate mode: hold traffic until calibration resolves, then either
  // pass through to the controller or answer everything with SLVERR.
  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_PASS      = 2'd1,
    ST_ERROR     = 2'd2
  } gate_state_t;

  // Error-responder write engine: AW -> W burst -> B.
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  // Error-responder read engine: AR -> R burst.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/swervolf_axi_err_resp.sv
// AXI subordinate that completes every burst with SLVERR and zero read data.
// Latency: B one cycle after the last W beat; first R beat one cycle after AR.
// Backpressure: one burst per channel direction in flight; B/R held until ready.
//
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_en              engines may only accept new AW/AR while high
//   i_aw*/o_awready   write address (only id is kept)
//   i_w*/o_wready     write data (only last/valid matter)
//   o_b*/i_bready     write response, always SLVERR
//   i_ar*/o_arready   read address (id and len kept)
//   o_r*/i_rready     read data, zero payload, SLVERR, len+1 beats
module swervolf_axi_err_resp
  import swervolf_ddr_gate_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [7:0]            i_arlen,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready
);

  wr_state_t             wr_state, wr_next;
  rd_state_t             rd_state, rd_next;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [ID_WIDTH-1:0]   rid_q;
  // Beats still to send after the one currently presented; 0 means the
  // presented beat is the last, so arlen=255 needs no ninth bit.
  logic [7:0]            beats_left;

  // ---- state registers ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_state   <= WR_IDLE;
      rd_state   <= RD_IDLE;
      bid_q      <= '0;
      rid_q      <= '0;
      beats_left <= '0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      if (o_awready && i_awvalid) begin
        bid_q <= i_awid;
      end
      if (o_arready && i_arvalid) begin
        rid_q      <= i_arid;
        beats_left <= i_arlen;
      end else if (o_rvalid && i_rready && beats_left != 8'd0) begin
        beats_left <= beats_left - 8'd1;
      end
    end
  end

  // ---- next-state ----
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (i_en && i_awvalid)   wr_next = WR_DATA;
      WR_DATA: if (i_wvalid && i_wlast) wr_next = WR_RESP;
      WR_RESP: if (i_bready)            wr_next = WR_IDLE;
      default:                          wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (i_en && i_arvalid)               rd_next = RD_DATA;
      RD_DATA: if (i_rready && beats_left == 8'd0)  rd_next = RD_IDLE;
      default:                                      rd_next = RD_IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    o_awready = i_en && (wr_state == WR_IDLE);
    o_wready  = (wr_state == WR_DATA);
    o_bvalid  = (wr_state == WR_RESP);
    o_bid     = bid_q;
    o_bresp   = (wr_state == WR_RESP) ? RESP_SLVERR : RESP_OKAY;

    o_arready = i_en && (rd_state == RD_IDLE);
    o_rvalid  = (rd_state == RD_DATA);
    o_rid     = rid_q;
    o_rdata   = '0;
    o_rresp   = (rd_state == RD_DATA) ? RESP_SLVERR : RESP_OKAY;
    o_rlast   = (rd_state == RD_DATA) && (beats_left == 8'd0);
  end

endmodule

// File: rtl/swervolf_ddr_gate.sv
// Gates the AXI path to the DDR controller on calibration outcome.
// Latency: zero-cycle combinational pass-through once calibrated; error path per responder.
// Backpressure: all readies low until calibration resolves; then controller or responder backpressure.
//
// Ports:
//   i_clk, i_rst                 controller user clock, async active-high reset
//   i_init_done, i_init_error    calibration result (sticky once acted upon)
//   i_aw*/i_w*/i_ar*, o_b*/o_r*  subordinate side from the CPU interconnect
//   o_m_*/i_m_*                  manager side toward the DDR controller
//   o_ready, o_error             registered PASS / ERROR indicators
module swervolf_ddr_gate
  import swervolf_ddr_gate_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_init_done,
  input  logic                    i_init_error,
  // subordinate side
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [31:0]             i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [31:0]             i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  // manager side
  output logic [ID_WIDTH-1:0]     o_m_awid,
  output logic [31:0]             o_m_awaddr,
  output logic [7:0]              o_m_awlen,
  output logic [2:0]              o_m_awsize,
  output logic [1:0]              o_m_awburst,
  output logic                    o_m_awvalid,
  input  logic                    i_m_awready,
  output logic [ID_WIDTH-1:0]     o_m_arid,
  output logic [31:0]             o_m_araddr,
  output logic [7:0]              o_m_arlen,
  output logic [2:0]              o_m_arsize,
  output logic [1:0]              o_m_arburst,
  output logic                    o_m_arvalid,
  input  logic                    i_m_arready,
  output logic [DATA_WIDTH-1:0]   o_m_wdata,
  output logic [DATA_WIDTH/8-1:0] o_m_wstrb,
  output logic                    o_m_wlast,
  output logic                    o_m_wvalid,
  input  logic                    i_m_wready,
  input  logic [ID_WIDTH-1:0]     i_m_bid,
  input  logic [1:0]              i_m_bresp,
  input  logic                    i_m_bvalid,
  output logic                    o_m_bready,
  input  logic [ID_WIDTH-1:0]     i_m_rid,
  input  logic [DATA_WIDTH-1:0]   i_m_rdata,
  input  logic [1:0]              i_m_rresp,
  input  logic                    i_m_rlast,
  input  logic                    i_m_rvalid,
  output logic                    o_m_rready,
  // status
  output logic                    o_ready,
  output logic                    o_error
);

  gate_state_t state, state_next;

  logic                  err_awready, err_wready, err_bvalid, err_arready;
  logic                  err_rvalid, err_rlast;
  logic [ID_WIDTH-1:0]   err_bid, err_rid;
  logic [1:0]            err_bresp, err_rresp;
  logic [DATA_WIDTH-1:0] err_rdata;

  // ---- state register; status flags track the state they decode ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_WAIT_INIT;
      o_ready <= 1'b0;
      o_error <= 1'b0;
    end else begin
      state   <= state_next;
      o_ready <= (state_next == ST_PASS);
      o_error <= (state_next == ST_ERROR);
    end
  end

  // ---- next-state: error outranks done; both outcomes are terminal ----
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_INIT: begin
        if (i_init_error)     state_next = ST_ERROR;
        else if (i_init_done) state_next = ST_PASS;
      end
      ST_PASS:  state_next = ST_PASS;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_WAIT_INIT;
    endcase
  end

  swervolf_axi_err_resp #(
    .ID_WIDTH   (ID_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_err_resp (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (state == ST_ERROR),
    .i_awid    (i_awid),
    .i_awvalid (i_awvalid),
    .o_awready (err_awready),
    .i_wlast   (i_wlast),
    .i_wvalid  (i_wvalid),
    .o_wready  (err_wready),
    .o_bid     (err_bid),
    .o_bresp   (err_bresp),
    .o_bvalid  (err_bvalid),
    .i_bready  (i_bready),
    .i_arid    (i_arid),
    .i_arlen   (i_arlen),
    .i_arvalid (i_arvalid),
    .o_arready (err_arready),
    .o_rid     (err_rid),
    .o_rdata   (err_rdata),
    .o_rresp   (err_rresp),
    .o_rlast   (err_rlast),
    .o_rvalid  (err_rvalid),
    .i_rready  (i_rready)
  );

  // ---- output mux: everything quiet unless a mode claims it ----
  always_comb begin
    o_awready   = 1'b0;
    o_arready   = 1'b0;
    o_wready    = 1'b0;
    o_bid       = '0;
    o_bresp     = RESP_OKAY;
    o_bvalid    = 1'b0;
    o_rid       = '0;
    o_rdata     = '0;
    o_rresp     = RESP_OKAY;
    o_rlast     = 1'b0;
    o_rvalid    = 1'b0;
    o_m_awid    = '0;
    o_m_awaddr  = '0;
    o_m_awlen   = '0;
    o_m_awsize  = '0;
    o_m_awburst = '0;
    o_m_awvalid = 1'b0;
    o_m_arid    = '0;
    o_m_araddr  = '0;
    o_m_arlen   = '0;
    o_m_arsize  = '0;
    o_m_arburst = '0;
    o_m_arvalid = 1'b0;
    o_m_wdata   = '0;
    o_m_wstrb   = '0;
    o_m_wlast   = 1'b0;
    o_m_wvalid  = 1'b0;
    o_m_bready  = 1'b0;
    o_m_rready  = 1'b0;
    case (state)
      ST_PASS: begin
        o_m_awid    = i_awid;
        o_m_awaddr  = i_awaddr;
        o_m_awlen   = i_awlen;
        o_m_awsize  = i_awsize;
        o_m_awburst = i_awburst;
        o_m_awvalid = i_awvalid;
        o_awready   = i_m_awready;
        o_m_arid    = i_arid;
        o_m_araddr  = i_araddr;
        o_m_arlen   = i_arlen;
        o_m_arsize  = i_arsize;
        o_m_arburst = i_arburst;
        o_m_arvalid = i_arvalid;
        o_arready   = i_m_arready;
        o_m_wdata   = i_wdata;
        o_m_wstrb   = i_wstrb;
        o_m_wlast   = i_wlast;
        o_m_wvalid  = i_wvalid;
        o_wready    = i_m_wready;
        o_bid       = i_m_bid;
        o_bresp     = i_m_bresp;
        o_bvalid    = i_m_bvalid;
        o_m_bready  = i_bready;
        o_rid       = i_m_rid;
        o_rdata     = i_m_rdata;
        o_rresp     = i_m_rresp;
        o_rlast     = i_m_rlast;
        o_rvalid    = i_m_rvalid;
        o_m_rready  = i_rready;
      end
      ST_ERROR: begin
        o_awready = err_awready;
        o_wready  = err_wready;
        o_bid     = err_bid;
        o_bresp   = err_bresp;
        o_bvalid  = err_bvalid;
        o_arready = err_arready;
        o_rid     = err_rid;
        o_rdata   = err_rdata;
        o_rresp   = err_rresp;
        o_rlast   = err_rlast;
        o_rvalid  = err_rvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_swervolf_ddr_gate.sv
// Testbench for swervolf_ddr_gate.
// Latency: n/a.
// Backpressure: n/a.
module tb_swervolf_ddr_gate;
  localparam int IW = 4;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_init_done, i_init_error;
  logic [IW-1:0] i_awid, i_arid, o_bid, o_rid;
  logic [31:0]   i_awaddr, i_araddr;
  logic [7:0]    i_awlen, i_arlen;
  logic [2:0]    i_awsize, i_arsize;
  logic [1:0]    i_awburst, i_arburst, o_bresp, o_rresp;
  logic          i_awvalid, o_awready, i_arvalid, o_arready;
  logic [DW-1:0] i_wdata, o_rdata;
  logic [SW-1:0] i_wstrb;
  logic          i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
  logic          o_rlast, o_rvalid, i_rready;
  logic [IW-1:0] o_m_awid, o_m_arid, i_m_bid, i_m_rid;
  logic [31:0]   o_m_awaddr, o_m_araddr;
  logic [7:0]    o_m_awlen, o_m_arlen;
  logic [2:0]    o_m_awsize, o_m_arsize;
  logic [1:0]    o_m_awburst, o_m_arburst, i_m_bresp, i_m_rresp;
  logic          o_m_awvalid, i_m_awready, o_m_arvalid, i_m_arready;
  logic [DW-1:0] o_m_wdata, i_m_rdata;
  logic [SW-1:0] o_m_wstrb;
  logic          o_m_wlast, o_m_wvalid, i_m_wready;
  logic          i_m_bvalid, o_m_bready, i_m_rlast, i_m_rvalid, o_m_rready;
  logic          o_ready, o_error;

  always #5 clk = ~clk;

  swervolf_ddr_gate #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_init_done(i_init_done), .i_init_error(i_init_error),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
    .o_wready(o_wready), .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid),
    .i_bready(i_bready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready),
    .o_m_awid(o_m_awid), .o_m_awaddr(o_m_awaddr), .o_m_awlen(o_m_awlen),
    .o_m_awsize(o_m_awsize), .o_m_awburst(o_m_awburst), .o_m_awvalid(o_m_awvalid),
    .i_m_awready(i_m_awready), .o_m_arid(o_m_arid), .o_m_araddr(o_m_araddr),
    .o_m_arlen(o_m_arlen), .o_m_arsize(o_m_arsize), .o_m_arburst(o_m_arburst),
    .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready), .o_m_wdata(o_m_wdata),
    .o_m_wstrb(o_m_wstrb), .o_m_wlast(o_m_wlast), .o_m_wvalid(o_m_wvalid),
    .i_m_wready(i_m_wready), .i_m_bid(i_m_bid), .i_m_bresp(i_m_bresp),
    .i_m_bvalid(i_m_bvalid), .o_m_bready(o_m_bready), .i_m_rid(i_m_rid),
    .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp), .i_m_rlast(i_m_rlast),
    .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready),
    .o_ready(o_ready), .o_error(o_error)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model of the error responder: remaining read beats and write phase.
  int            rd_left;
  logic [IW-1:0] rd_id;
  int            wr_phase;   // 0: awaiting AW, 1: collecting W, 2: B owed
  logic [IW-1:0] wr_id;
  int            beats;

  typedef struct {
    logic       err_mode;
    logic [9:0] in;   // {awvalid,m_awready,wvalid,m_wready,arvalid,m_arready,m_bvalid,bready,m_rvalid,rready}
    logic [9:0] exp;  // {m_awvalid,awready,m_wvalid,wready,m_arvalid,arready,bvalid,m_bready,rvalid,m_rready}
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_init_done = 0; i_init_error = 0;
    i_awid = 0; i_awaddr = 0; i_awlen = 0; i_awsize = 0; i_awburst = 0; i_awvalid = 0;
    i_arid = 0; i_araddr = 0; i_arlen = 0; i_arsize = 0; i_arburst = 0; i_arvalid = 0;
    i_wdata = 0; i_wstrb = 0; i_wlast = 0; i_wvalid = 0; i_bready = 0; i_rready = 0;
    i_m_awready = 0; i_m_arready = 0; i_m_wready = 0;
    i_m_bid = 0; i_m_bresp = 0; i_m_bvalid = 0;
    i_m_rid = 0; i_m_rdata = 0; i_m_rresp = 0; i_m_rlast = 0; i_m_rvalid = 0;
  endtask

  // Every handshake signal, status flag and response code must be zero.
  task automatic chk_quiet(input string name);
    chk(name, {o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_m_awvalid, o_m_arvalid,
               o_m_wvalid, o_m_bready, o_m_rready, o_ready, o_error, o_bresp, o_rresp}, 0);
  endtask

  task automatic apply_tbl(input logic mode);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].err_mode != mode) continue;
      {i_awvalid, i_m_awready, i_wvalid, i_m_wready, i_arvalid, i_m_arready,
       i_m_bvalid, i_bready, i_m_rvalid, i_rready} = tbl[i].in;
      #1;
      chk($sformatf("tbl%0d", i), {o_m_awvalid, o_awready, o_m_wvalid, o_wready, o_m_arvalid,
          o_arready, o_bvalid, o_m_bready, o_rvalid, o_m_rready}, tbl[i].exp);
    end
    idle_inputs();
  endtask

  task automatic randomize_inputs();
    i_awid = IW'($urandom); i_awaddr = $urandom; i_awlen = 8'($urandom);
    i_awsize = 3'($urandom); i_awburst = 2'($urandom); i_awvalid = 1'($urandom);
    i_arid = IW'($urandom); i_araddr = $urandom; i_arlen = 8'($urandom_range(0, 5));
    i_arsize = 3'($urandom); i_arburst = 2'($urandom); i_arvalid = 1'($urandom);
    i_wdata = {$urandom, $urandom}; i_wstrb = SW'($urandom);
    i_wlast = ($urandom_range(0, 3) == 0); i_wvalid = 1'($urandom);
    i_bready = 1'($urandom); i_rready = 1'($urandom);
    i_m_awready = 1'($urandom); i_m_arready = 1'($urandom); i_m_wready = 1'($urandom);
    i_m_bid = IW'($urandom); i_m_bresp = 2'($urandom); i_m_bvalid = 1'($urandom);
    i_m_rid = IW'($urandom); i_m_rdata = {$urandom, $urandom}; i_m_rresp = 2'($urandom);
    i_m_rlast = 1'($urandom); i_m_rvalid = 1'($urandom);
    i_init_done = 1'($urandom); i_init_error = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, err_cnt=%0d", err_cnt);
    $fatal(1);
  end

  initial begin
    // In PASS the handshakes cross over; in idle ERROR the responder is ready for AW/AR only.
    tbl[0] = '{1'b0, 10'b1010101010, 10'b1010101010};
    tbl[1] = '{1'b0, 10'b0101010101, 10'b0101010101};
    tbl[2] = '{1'b0, 10'b1111111111, 10'b1111111111};
    tbl[3] = '{1'b0, 10'b1100110000, 10'b1100110000};
    tbl[4] = '{1'b0, 10'b0000001111, 10'b0000001111};
    tbl[5] = '{1'b0, 10'b1001100110, 10'b1001100110};
    tbl[6] = '{1'b1, 10'b1111111111, 10'b0100010000};
    tbl[7] = '{1'b1, 10'b0000000000, 10'b0100010000};
    tbl[8] = '{1'b1, 10'b0101010101, 10'b0100010000};
    tbl[9] = '{1'b1, 10'b1010101010, 10'b0100010000};

    rst = 1;
    idle_inputs();
    tick(); tick();
    chk_quiet("reset_quiet");
    rst = 0;

    // Calibration pending: nothing moves for 100 cycles.
    i_awvalid = 1; i_m_awready = 1;
    for (int c = 0; c < 100; c++) begin
      #1;
      chk("wait_init_hold", {o_awready, o_m_awvalid, o_ready, o_error}, 0);
      tick();
    end
    idle_inputs();

    // Calibration done -> PASS.
    i_init_done = 1;
    #1;
    chk("ready_before_edge", o_ready, 0);
    tick();
    i_init_done = 0;
    #1;
    chk("pass_status", {o_ready, o_error}, 2'b10);
    apply_tbl(1'b0);

    i_arvalid = 1; i_arid = 3; i_arlen = 3; i_araddr = 32'h8000_0040; i_m_arready = 1;
    #1;
    chk("pass_ar_fwd", {o_m_arid, o_m_araddr, o_m_arlen, o_m_arvalid}, {4'd3, 32'h8000_0040, 8'd3, 1'b1});
    chk("pass_arready", o_arready, 1);
    tick();
    idle_inputs();
    for (int b = 1; b <= 4; b++) begin
      i_m_rvalid = 1; i_m_rid = 3; i_m_rdata = 64'hA5A5_0000_0000_0000 | 64'(b);
      i_m_rlast = (b == 4); i_rready = 1;
      #1;
      chk($sformatf("pass_r_beat%0d", b), {o_rvalid, o_rid, o_rdata, o_rresp, o_rlast},
          {1'b1, 4'd3, 64'hA5A5_0000_0000_0000 | 64'(b), 2'b00, 1'(b == 4)});
      chk("pass_m_rready", o_m_rready, 1);
      tick();
    end
    idle_inputs();

    // Random traffic in PASS: every output mirrors its counterpart; status frozen.
    for (int n = 0; n < 200; n++) begin
      randomize_inputs();
      #1;
      chk("rnd_pass_aw", {o_m_awid, o_m_awaddr, o_m_awlen, o_m_awsize, o_m_awburst, o_m_awvalid},
          {i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awvalid});
      chk("rnd_pass_ar", {o_m_arid, o_m_araddr, o_m_arlen, o_m_arsize, o_m_arburst, o_m_arvalid},
          {i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arvalid});
      chk("rnd_pass_w", {o_m_wdata, o_m_wstrb, o_m_wlast, o_m_wvalid}, {i_wdata, i_wstrb, i_wlast, i_wvalid});
      chk("rnd_pass_b", {o_bid, o_bresp, o_bvalid}, {i_m_bid, i_m_bresp, i_m_bvalid});
      chk("rnd_pass_r", {o_rid, o_rdata, o_rresp, o_rlast, o_rvalid},
          {i_m_rid, i_m_rdata, i_m_rresp, i_m_rlast, i_m_rvalid});
      chk("rnd_pass_rdy", {o_awready, o_arready, o_wready, o_m_bready, o_m_rready},
          {i_m_awready, i_m_arready, i_m_wready, i_bready, i_rready});
      chk("rnd_pass_status", {o_ready, o_error}, 2'b10);
      tick();
    end
    idle_inputs();

    // Reset, then done and error together -> ERROR wins.
    rst = 1; tick(); rst = 0;
    i_init_done = 1; i_init_error = 1;
    #1;
    chk("error_before_edge", o_error, 0);
    tick();
    idle_inputs();
    #1;
    chk("error_status", {o_ready, o_error}, 2'b01);
    i_init_done = 1; tick(); i_init_done = 0; #1;
    chk("error_terminal", {o_ready, o_error}, 2'b01);
    apply_tbl(1'b1);

    i_arvalid = 1; i_arid = 5; i_arlen = 0; i_m_arready = 1;
    #1;
    chk("err_ar_single_rdy", {o_arready, o_m_arvalid}, 2'b10);
    tick();
    idle_inputs();
    #1;
    chk("err_r_single", {o_rvalid, o_rid, o_rresp, o_rlast, o_rdata}, {1'b1, 4'd5, 2'b10, 1'b1, 64'd0});
    tick();
    chk("err_r_single_hold", {o_rvalid, o_rid}, {1'b1, 4'd5});
    i_rready = 1; tick(); i_rready = 0; #1;
    chk("err_r_single_done", {o_rvalid, o_arready}, 2'b01);

    // 256-beat read with toggling rready.
    i_arvalid = 1; i_arid = 9; i_arlen = 255;
    #1;
    chk("err_ar256_rdy", o_arready, 1);
    tick();
    idle_inputs();
    beats = 0;
    for (int c = 0; c < 1200; c++) begin
      i_rready = ((c % 3) != 1);
      #1;
      if (o_rvalid && i_rready) begin
        beats++;
        chk("err_r256_beat", {o_rlast, o_rdata, o_rresp, o_rid}, {1'(beats == 256), 64'd0, 2'b10, 4'd9});
      end
      if (o_rvalid && i_rready && o_rlast) begin
        tick();
        break;
      end
      tick();
    end
    idle_inputs();
    #1;
    chk("err_r256_count", beats, 256);
    chk("err_r256_idle", {o_rvalid, o_arready}, 2'b01);

    // W before AW is ignored; then a 2-beat write and held SLVERR response.
    i_wvalid = 1; i_wlast = 0;
    for (int c = 0; c < 3; c++) begin
      #1; chk("err_w_early", o_wready, 0); tick();
    end
    i_awvalid = 1; i_awid = 7; i_awlen = 1;
    #1;
    chk("err_aw_accept", {o_awready, o_wready}, 2'b10);
    tick();
    i_awvalid = 0;
    #1; chk("err_w_beat1", o_wready, 1); tick();
    i_wlast = 1;
    #1; chk("err_w_beat2", o_wready, 1); tick();
    i_wvalid = 0; i_wlast = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("err_b_hold", {o_bvalid, o_bid, o_bresp, o_awready}, {1'b1, 4'd7, 2'b10, 1'b0});
      tick();
    end
    i_bready = 1;
    #1; chk("err_b_take", o_bvalid, 1); tick();
    i_bready = 0;
    #1; chk("err_b_done", {o_bvalid, o_awready}, 2'b01);

    // Random concurrent traffic in ERROR against the transaction model.
    rd_left = 0; wr_phase = 0; rd_id = 0; wr_id = 0;
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      #1;
      chk("rnd_err_awready", o_awready, wr_phase == 0);
      chk("rnd_err_wready", o_wready, wr_phase == 1);
      chk("rnd_err_bvalid", o_bvalid, wr_phase == 2);
      if (wr_phase == 2) chk("rnd_err_b", {o_bid, o_bresp}, {wr_id, 2'b10});
      chk("rnd_err_arready", o_arready, rd_left == 0);
      chk("rnd_err_rvalid", o_rvalid, rd_left > 0);
      if (rd_left > 0)
        chk("rnd_err_r", {o_rid, o_rlast, o_rdata, o_rresp}, {rd_id, 1'(rd_left == 1), 64'd0, 2'b10});
      chk("rnd_err_m_quiet", {o_m_awvalid, o_m_arvalid, o_m_wvalid, o_m_bready, o_m_rready}, 0);
      chk("rnd_err_status", {o_ready, o_error}, 2'b01);
      tick();
      case (wr_phase)
        0: if (i_awvalid) begin wr_phase = 1; wr_id = i_awid; end
        1: if (i_wvalid && i_wlast) wr_phase = 2;
        default: if (i_bready) wr_phase = 0;
      endcase
      if (rd_left == 0) begin
        if (i_arvalid) begin rd_left = int'(i_arlen) + 1; rd_id = i_arid; end
      end else if (i_rready) begin
        rd_left--;
      end
    end

    // Drain back to idle.
    idle_inputs();
    i_wvalid = 1; i_wlast = 1; i_bready = 1; i_rready = 1;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (o_awready && o_arready) break;
      tick();
    end
    chk("drain_idle", {o_awready, o_arready}, 2'b11);
    idle_inputs();

    // Reset in the middle of a 4-beat read.
    i_arvalid = 1; i_arid = 6; i_arlen = 3;
    tick();
    i_arvalid = 0; i_rready = 1;
    #1; chk("rst_mid_beat1", {o_rvalid, o_rid}, {1'b1, 4'd6});
    tick();
    #1; chk("rst_mid_beat2", {o_rvalid, o_rlast}, 2'b10);
    rst = 1;
    #1;
    chk_quiet("rst_mid_async");
    tick(); tick();
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      #1; chk_quiet("rst_mid_wait_init"); tick();
    end
    i_init_error = 1; tick(); i_init_error = 0;
    #1;
    chk("rst_mid_no_stale", {o_error, o_rvalid, o_arready}, 3'b101);
    tick();
    chk("rst_mid_no_stale2", o_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
